// File: rtl/mems_pkg.sv
// Shared types and helpers for the microphone beamforming path.
package mems_pkg;

  localparam int DEF_CHANNELS   = 6;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_GAIN_SHIFT = 3;

  // Accumulator holds the sum of all channels; product holds acc * 4-bit gain.
  localparam int DEF_ACC_W  = DEF_WIDTH + 3;
  localparam int DEF_PROD_W = DEF_WIDTH + 7;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_SCALE,
    ST_OUT
  } state_t;

  // Clamp a wide signed value into the sample range.
  function automatic sample_t sat_sample(input logic signed [DEF_PROD_W-1:0] v);
    logic [DEF_PROD_W-DEF_WIDTH:0] hi;
    hi = v[DEF_PROD_W-1:DEF_WIDTH-1];
    if (hi == '0 || hi == '1)
      return v[DEF_WIDTH-1:0];
    else if (v[DEF_PROD_W-1])
      return {1'b1, {(DEF_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DEF_WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Per-channel sample history: simple dual-port RAM with registered read.
// Storage is deliberately not reset so it maps onto block RAM.
module delay_ram
  import mems_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int AW      = 8,
  parameter int ENTRIES = DEF_CHANNELS * DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port share one clock.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_sum.sv
// Delay-and-sum beamformer: stores each frame per channel, reads every channel
// back at its own delay, sums, applies gain and saturates to one sample.
module delay_sum
  import mems_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DW         = $clog2(DEF_DEPTH),
  parameter int GAIN_SHIFT = DEF_GAIN_SHIFT
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CHANNELS*WIDTH-1:0] mics,
  input  logic [CHANNELS*DW-1:0] delays,
  input  logic [3:0]             gain,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out,
  output logic                   busy,
  output logic                   overrun
);

  localparam int CW     = $clog2(CHANNELS);
  localparam int AW     = CW + DW;
  localparam int ACC_W  = WIDTH + 3;
  localparam int PROD_W = WIDTH + 7;

  state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [DW-1:0] wp_q, hc_q;
  logic          last_ch;

  logic [CHANNELS*WIDTH-1:0] mics_q;
  logic [CHANNELS*DW-1:0]    delays_q;
  logic [3:0]                gain_q;

  logic [WIDTH-1:0] mic_arr [CHANNELS];
  logic [DW-1:0]    dly_arr [CHANNELS];
  logic [DW-1:0]    cur_dly, rptr;

  logic [WIDTH-1:0] rd_data;
  logic             rd_vld_q, rd_mask_q;

  logic signed [ACC_W-1:0]  acc_q, rd_ext, rd_term;
  logic signed [PROD_W-1:0] acc_ext, gain_ext, prod, shifted;

  logic [WIDTH-1:0] out_q;
  logic             overrun_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign mic_arr[c] = mics_q[c*WIDTH +: WIDTH];
    assign dly_arr[c] = delays_q[c*DW +: DW];
  end

  assign last_ch = (ch_q == CW'(CHANNELS - 1));
  assign cur_dly = dly_arr[ch_q];
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign rptr    = wp_q - cur_dly;

  // Sequencer next-state: write all channels, read all channels, then finish.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_WRITE;
          ch_d    = '0;
        end
      end
      ST_WRITE: begin
        if (last_ch) begin
          state_d = ST_READ;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      ST_READ: begin
        if (last_ch) begin
          state_d = ST_DRAIN;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_SCALE;
      ST_SCALE: state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and channel counter.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Frame pointer and warm-up history count advance once per completed frame.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      hc_q <= '0;
    end else if (state_q == ST_OUT) begin
      wp_q <= wp_q + 1'b1;
      if (hc_q != DW'(DEPTH - 1)) hc_q <= hc_q + 1'b1;
    end
  end

  // Latch the frame and its controls only when accepted; strobes while busy are dropped.
  always_ff @(posedge ck) begin
    if (state_q == ST_IDLE && in_valid) begin
      mics_q   <= mics;
      delays_q <= delays;
      gain_q   <= gain;
    end
  end

  delay_ram #(
    .WIDTH  (WIDTH),
    .AW     (AW),
    .ENTRIES(CHANNELS * DEPTH)
  ) u_ram (
    .clk_i  (ck),
    .we_i   (state_q == ST_WRITE),
    .waddr_i({ch_q, wp_q}),
    .wdata_i(mic_arr[ch_q]),
    .re_i   (state_q == ST_READ),
    .raddr_i({ch_q, rptr}),
    .rdata_o(rd_data)
  );

  // Track which RAM reads land next cycle and whether they reach before history starts.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_mask_q <= 1'b0;
    end else begin
      rd_vld_q  <= (state_q == ST_READ);
      rd_mask_q <= (cur_dly > hc_q);
    end
  end

  assign rd_ext  = {{(ACC_W-WIDTH){rd_data[WIDTH-1]}}, rd_data};
  assign rd_term = rd_mask_q ? '0 : rd_ext;

  // Accumulator: cleared while writing, summed as read data returns.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (state_q == ST_WRITE) begin
      acc_q <= '0;
    end else if (rd_vld_q) begin
      acc_q <= acc_q + rd_term;
    end
  end

  assign acc_ext  = {{(PROD_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign gain_ext = {{(PROD_W-4){1'b0}}, gain_q};
  assign prod     = acc_ext * gain_ext;
  assign shifted  = prod >>> GAIN_SHIFT;

  // Output sample register, held between results.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else if (state_q == ST_SCALE) begin
      out_q <= sat_sample(shifted);
    end
  end

  // Overrun flag pulses for one cycle after a strobe arrives while a frame is in flight.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= in_valid && (state_q != ST_IDLE);
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_sum.sv
module tb_delay_sum;

  localparam int CH = 6;
  localparam int W  = 16;
  localparam int DW = 5;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [CH*W-1:0]  mics = '0;
  logic [CH*DW-1:0] delays = '0;
  logic [3:0]       gain = '0;
  logic             out_valid;
  logic [W-1:0]     dout;
  logic             busy;
  logic             overrun;

  delay_sum dut (
    .ck       (ck),
    .rst      (rst),
    .in_valid (in_valid),
    .mics     (mics),
    .delays   (delays),
    .gain     (gain),
    .out_valid(out_valid),
    .out      (dout),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int passes = 0;

  // Reference history: every accepted frame since reset, flattened frame*CH+channel.
  int hist[$];

  int obs_out, obs_lat, obs_vcnt, obs_ovr;
  bit obs_busy_ok;

  task automatic model_reset();
    hist.delete();
  endtask

  task automatic model_push(input logic [CH*W-1:0] m);
    for (int c = 0; c < CH; c++) hist.push_back(int'($signed(m[c*W +: W])));
  endtask

  // Expected output for the most recently pushed frame.
  function automatic int model_expect(input logic [CH*DW-1:0] d, input int g);
    int n, sum, dc, sh;
    n   = hist.size() / CH - 1;
    sum = 0;
    for (int c = 0; c < CH; c++) begin
      dc = int'(d[c*DW +: DW]);
      if (dc <= n) sum += hist[(n - dc) * CH + c];
    end
    sh = (sum * g) >>> 3;
    if (sh > 32767) return 32767;
    if (sh < -32768) return -32768;
    return sh;
  endfunction

  function automatic logic [CH*W-1:0] pack_mics(input int v0, v1, v2, v3, v4, v5);
    logic [CH*W-1:0] r;
    r = {v5[W-1:0], v4[W-1:0], v3[W-1:0], v2[W-1:0], v1[W-1:0], v0[W-1:0]};
    return r;
  endfunction

  function automatic logic [CH*DW-1:0] pack_dly(input int d0, d1, d2, d3, d4, d5);
    logic [CH*DW-1:0] r;
    r = {d5[DW-1:0], d4[DW-1:0], d3[DW-1:0], d2[DW-1:0], d1[DW-1:0], d0[DW-1:0]};
    return r;
  endfunction

  // Drives one frame strobe, optionally a second strobe at cycle inject_at,
  // and observes 24 cycles after the accepting edge.
  task automatic drive_frame(input logic [CH*W-1:0] m, input logic [CH*DW-1:0] d,
                             input logic [3:0] g, input int inject_at);
    @(negedge ck);
    mics = m; delays = d; gain = g; in_valid = 1'b1;
    @(posedge ck);
    obs_out = 0; obs_lat = -1; obs_vcnt = 0; obs_ovr = 0; obs_busy_ok = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge ck);
      if (out_valid) begin
        if (obs_vcnt == 0) begin
          obs_lat = i;
          obs_out = $signed(dout);
        end
        obs_vcnt++;
      end
      if (busy !== (i <= 15)) obs_busy_ok = 1'b0;
      if (overrun) obs_ovr++;
      in_valid = (i == inject_at);
      if (in_valid) mics = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic apply_reset();
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [CH*W-1:0] m;
    rst = 1'b1;
    repeat (3) @(negedge ck);
    checks++; if (dout !== 16'd0) $display("FAIL rst_out got=%0d want=0", dout); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun got=%b want=0", overrun); else passes++;
    rst = 1'b0;
    model_reset();
    m = pack_mics(100, 100, 100, 100, 100, 100);
    model_push(m);
    drive_frame(m, '0, 4'd8, 0);
    checks++; if (obs_out !== 600) $display("FAIL first_out got=%0d want=600", obs_out); else passes++;
    checks++; if (obs_lat !== 15) $display("FAIL first_latency got=%0d want=15", obs_lat); else passes++;
    checks++; if (obs_busy_ok !== 1'b1) $display("FAIL first_busy_window got=0 want=1"); else passes++;
    checks++; if (obs_vcnt !== 1) $display("FAIL first_valid_count got=%0d want=1", obs_vcnt); else passes++;
  endtask

  task automatic test_delay_per_channel();
    logic [CH*W-1:0] m;
    int exp;
    apply_reset();
    for (int n = 0; n < 10; n++) begin
      m = pack_mics(n, n, n, n, n, n);
      model_push(m);
      exp = 0;
      for (int c = 0; c < CH; c++) if (c <= n) exp += n - c;
      drive_frame(m, pack_dly(0, 1, 2, 3, 4, 5), 4'd8, 0);
      checks++; if (obs_out !== exp) $display("FAIL delay_f%0d got=%0d want=%0d", n, obs_out, exp); else passes++;
      checks++; if (obs_lat !== 15) $display("FAIL delay_lat_f%0d got=%0d want=15", n, obs_lat); else passes++;
    end
  endtask

  task automatic test_saturation_gain();
    int mv[4]  = '{32767, -32768, 1000, 1234};
    int gv[4]  = '{15, 15, 4, 0};
    int ev[4]  = '{32767, -32768, 3000, 0};
    logic [CH*W-1:0] m;
    for (int k = 0; k < 4; k++) begin
      m = pack_mics(mv[k], mv[k], mv[k], mv[k], mv[k], mv[k]);
      model_push(m);
      drive_frame(m, '0, 4'(gv[k]), 0);
      checks++; if (obs_out !== ev[k]) $display("FAIL sat_case%0d got=%0d want=%0d", k, obs_out, ev[k]); else passes++;
    end
  endtask

  task automatic test_random();
    logic [CH*W-1:0]  m;
    logic [CH*DW-1:0] d;
    logic [3:0]       g;
    int exp;
    for (int k = 0; k < 20; k++) begin
      m = {$urandom, $urandom, $urandom};
      d = CH*DW'($urandom);
      g = 4'($urandom_range(0, 15));
      model_push(m);
      exp = model_expect(d, int'(g));
      drive_frame(m, d, g, 0);
      checks++; if (obs_out !== exp) $display("FAIL rand_f%0d got=%0d want=%0d", k, obs_out, exp); else passes++;
      checks++; if (obs_busy_ok !== 1'b1) $display("FAIL rand_busy_f%0d got=0 want=1", k); else passes++;
    end
  endtask

  task automatic test_wrap();
    logic [CH*W-1:0] m;
    int exp;
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      m = pack_mics(n, 0, 0, 0, 0, 0);
      model_push(m);
      exp = (n >= 31) ? n - 31 : 0;
      drive_frame(m, pack_dly(31, 0, 0, 0, 0, 0), 4'd8, 0);
      checks++; if (obs_out !== exp) $display("FAIL wrap_f%0d got=%0d want=%0d", n, obs_out, exp); else passes++;
    end
  endtask

  task automatic test_overrun();
    logic [CH*W-1:0] m;
    int exp;
    m = pack_mics(11, -22, 33, -44, 55, 66);
    model_push(m);
    exp = model_expect('0, 8);
    drive_frame(m, '0, 4'd8, 8);
    checks++; if (obs_ovr !== 1) $display("FAIL overrun_pulses got=%0d want=1", obs_ovr); else passes++;
    checks++; if (obs_out !== exp) $display("FAIL overrun_out got=%0d want=%0d", obs_out, exp); else passes++;
    checks++; if (obs_lat !== 15) $display("FAIL overrun_latency got=%0d want=15", obs_lat); else passes++;
    checks++; if (obs_vcnt !== 1) $display("FAIL overrun_valid_count got=%0d want=1", obs_vcnt); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [CH*W-1:0] m;
    int exp;
    @(negedge ck);
    mics = pack_mics(500, 500, 500, 500, 500, 500); delays = '0; gain = 4'd8; in_valid = 1'b1;
    @(posedge ck);
    for (int i = 1; i <= 10; i++) begin
      @(negedge ck);
      in_valid = 1'b0;
    end
    checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got=%b want=1", busy); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (dout !== 16'd0) $display("FAIL midrst_out got=%0d want=0", dout); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", busy); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b want=0", out_valid); else passes++;
    @(negedge ck);
    rst = 1'b0;
    model_reset();
    m = {$urandom, $urandom, $urandom};
    model_push(m);
    exp = model_expect(pack_dly(0, 3, 3, 3, 3, 3), 8);
    drive_frame(m, pack_dly(0, 3, 3, 3, 3, 3), 4'd8, 0);
    checks++; if (obs_out !== exp) $display("FAIL midrst_next_out got=%0d want=%0d", obs_out, exp); else passes++;
    checks++; if (obs_lat !== 15) $display("FAIL midrst_next_latency got=%0d want=15", obs_lat); else passes++;
  endtask

  initial begin
    test_reset();
    test_delay_per_channel();
    test_saturation_gain();
    test_random();
    test_wrap();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
